rx_frame_sequencer: RTL and testbench

Receive-frame controller clocked by the 3x-baud oversampling clock of the UART receiver. It sequences the sampler across one serial frame: majority-votes each bit from three samples, assembles data LSB-first, checks optional parity and one or two stop bits, and then raises a stop request. The stop request tells the system-clock receiver controller to re-assert the sampler reset. All state lives for exactly one frame: the controller releases the reset at start-bit detection and asserts it again after `stop_req_o`.

---
 rtl/rx_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_rx_frame_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer.sv
// Purpose: sequences the UART sampler over one serial frame (start, data LSB-first, parity, stop bits).
// Latency: stop_req_o rises 3*(1+N+P+S) rx_sampler_clk edges after reset release; 3 edges on a false start.
// Backpressure: none; results hold in DONE/ABORT until rx_sampler_reset is asserted again.
//
// Ports:
//   rx_sampler_clk    3x-baud oversampling clock, posedge active
//   rx_sampler_reset  async active-low; held low between frames, released at start-bit detection
//   rx_i              serial line, synchronous to rx_sampler_clk
//   cfg_data_bits     data-bit count minus 5 (5..8 bits)
//   cfg_parity        00/11 none, 01 odd, 10 even
//   cfg_stop2         1 = two stop bits
//   data_o            received data, right-justified, upper bits zero
//   busy_o            frame in progress
//   stop_req_o        frame finished; sampler reset should be re-asserted
//   parity_err_o      parity mismatch (sticky)
//   frame_err_o       a stop bit sampled 0 (sticky)
//   break_o           all data, parity and first stop bit were 0
//   false_start_o     start bit voted 1
`timescale 1ns/1ps
module rx_frame_sequencer #(
   parameter int DATA_MAX = 8
) (
   input  logic                rx_sampler_clk,
   input  logic                rx_sampler_reset,
   input  logic                rx_i,
   input  logic [1:0]          cfg_data_bits,
   input  logic [1:0]          cfg_parity,
   input  logic                cfg_stop2,
   output logic [DATA_MAX-1:0] data_o,
   output logic                busy_o,
   output logic                stop_req_o,
   output logic                parity_err_o,
   output logic                frame_err_o,
   output logic                break_o,
   output logic                false_start_o
);

   localparam logic [2:0] ST_START  = 3'd0;
   localparam logic [2:0] ST_DATA   = 3'd1;
   localparam logic [2:0] ST_PARITY = 3'd2;
   localparam logic [2:0] ST_STOP1  = 3'd3;
   localparam logic [2:0] ST_STOP2  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ABORT  = 3'd6;

   logic [2:0]          state;
   logic [1:0]          ph;
   logic [1:0]          samp;
   logic [DATA_MAX-1:0] shreg;
   logic [2:0]          bit_cnt;
   logic                par_acc;
   logic                seen_one;   // any 1 among data/parity bits, for break detection

   logic                vote;
   logic                par_en;
   logic                par_odd;
   logic                last_data;
   logic [3:0]          shift_amt;
   logic [DATA_MAX-1:0] shreg_nxt;

   // Majority of the two stored samples and the live sample taken on the decision edge.
   assign vote      = (samp[1] & samp[0]) | (samp[1] & rx_i) | (samp[0] & rx_i);
   assign par_en    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
   assign par_odd   = (cfg_parity == 2'b01);
   assign last_data = (bit_cnt == (3'(cfg_data_bits) + 3'd4));
   // Bits arrive LSB-first into the top of shreg; shift right to right-justify short words.
   assign shift_amt = 4'(DATA_MAX) - (4'd5 + {2'b00, cfg_data_bits});
   assign shreg_nxt = {vote, shreg[DATA_MAX-1:1]};

   assign busy_o     = (state != ST_DONE) && (state != ST_ABORT);
   assign stop_req_o = (state == ST_DONE) || (state == ST_ABORT);

   always_ff @(posedge rx_sampler_clk or negedge rx_sampler_reset) begin
      if (!rx_sampler_reset) begin
         state         <= ST_START;
         ph            <= 2'd0;
         samp          <= 2'b00;
         shreg         <= '0;
         bit_cnt       <= 3'd0;
         par_acc       <= 1'b0;
         seen_one      <= 1'b0;
         data_o        <= '0;
         parity_err_o  <= 1'b0;
         frame_err_o   <= 1'b0;
         break_o       <= 1'b0;
         false_start_o <= 1'b0;
      end else if (busy_o) begin
         // Sampling freezes once terminal so every output holds for the synchronizer.
         samp <= {samp[0], rx_i};
         ph   <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
         if (ph == 2'd2) begin
            case (state)
               ST_START: begin
                  if (vote) begin
                     false_start_o <= 1'b1;
                     state         <= ST_ABORT;
                  end else begin
                     bit_cnt <= 3'd0;
                     state   <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  shreg    <= shreg_nxt;
                  par_acc  <= par_acc ^ vote;
                  seen_one <= seen_one | vote;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (last_data) begin
                     data_o <= shreg_nxt >> shift_amt;
                     state  <= par_en ? ST_PARITY : ST_STOP1;
                  end
               end
               ST_PARITY: begin
                  seen_one <= seen_one | vote;
                  if ((par_acc ^ vote) != par_odd)
                     parity_err_o <= 1'b1;
                  state <= ST_STOP1;
               end
               ST_STOP1: begin
                  if (!vote) begin
                     frame_err_o <= 1'b1;
                     break_o     <= ~seen_one;
                     state       <= ST_DONE;
                  end else begin
                     state <= cfg_stop2 ? ST_STOP2 : ST_DONE;
                  end
               end
               ST_STOP2: begin
                  if (!vote)
                     frame_err_o <= 1'b1;
                  state <= ST_DONE;
               end
               ST_DONE, ST_ABORT: ;
               default: state <= ST_ABORT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Purpose: directed frames against rx_frame_sequencer with a queue-based scoreboard.
// Latency: each frame's expected data, flags and completion edge are checked when stop_req_o rises.
// Backpressure: none; stimulus and monitor run independently.
`timescale 1ns/1ps
module tb_rx_frame_sequencer;

   logic       rx_sampler_clk = 1'b0;
   logic       rx_sampler_reset = 1'b0;
   logic       rx_i = 1'b1;
   logic [1:0] cfg_data_bits = 2'd3;
   logic [1:0] cfg_parity = 2'd0;
   logic       cfg_stop2 = 1'b0;
   logic [7:0] data_o;
   logic       busy_o, stop_req_o, parity_err_o, frame_err_o, break_o, false_start_o;

   rx_frame_sequencer #(.DATA_MAX(8)) dut (
      .rx_sampler_clk   (rx_sampler_clk),
      .rx_sampler_reset (rx_sampler_reset),
      .rx_i             (rx_i),
      .cfg_data_bits    (cfg_data_bits),
      .cfg_parity       (cfg_parity),
      .cfg_stop2        (cfg_stop2),
      .data_o           (data_o),
      .busy_o           (busy_o),
      .stop_req_o       (stop_req_o),
      .parity_err_o     (parity_err_o),
      .frame_err_o      (frame_err_o),
      .break_o          (break_o),
      .false_start_o    (false_start_o)
   );

   always #5 rx_sampler_clk = ~rx_sampler_clk;

   // flags = {parity_err, frame_err, break, false_start}
   typedef struct {
      logic [7:0] data;
      logic [3:0] flags;
      int         done_edge;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Frame as bit list, index 0 = start bit; unused trailing positions idle high.
   function automatic logic [39:0] frame_bits(input logic [7:0] d, input int n, input bit has_par,
                                              input logic pbit, input logic s1, input logic s2);
      logic [39:0] b;
      int idx;
      b = '1;
      b[0] = 1'b0;
      for (int i = 0; i < n; i++) b[1+i] = d[i];
      idx = 1 + n;
      if (has_par) begin
         b[idx] = pbit;
         idx++;
      end
      b[idx]   = s1;
      b[idx+1] = s2;
      return b;
   endfunction

   // Per-edge line: element e-1 is the rx_i value presented at edge e after release.
   function automatic logic [127:0] expand(input logic [39:0] b);
      logic [127:0] l;
      l = '1;
      for (int i = 0; i < 40; i++)
         for (int j = 0; j < 3; j++)
            l[3*i+j] = b[i];
      return l;
   endfunction

   task automatic push(input logic [7:0] d, input logic [3:0] f, input int e);
      exp_t x;
      x.data = d;
      x.flags = f;
      x.done_edge = e;
      exp_q.push_back(x);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rst_data"}, {24'd0, data_o}, 32'h0);
      check({tag, "_rst_status"},
            {26'd0, busy_o, stop_req_o, parity_err_o, frame_err_o, break_o, false_start_o},
            32'h20);
   endtask

   // Runs one frame for a fixed edge budget; rst_at > 0 aborts by asserting reset after that edge.
   task automatic run_frame(input string tag, input logic [127:0] line, input logic [1:0] db,
                            input logic [1:0] par, input logic st2, input int rst_at);
      int e;
      @(negedge rx_sampler_clk);
      rx_sampler_reset = 1'b0;
      cfg_data_bits = db;
      cfg_parity = par;
      cfg_stop2 = st2;
      rx_i = line[0];
      @(negedge rx_sampler_clk);
      check_reset_vals(tag);
      rx_sampler_reset = 1'b1;
      e = 1;
      while (e <= 45) begin
         @(negedge rx_sampler_clk);
         rx_i = line[e];
         if (e == rst_at) begin
            rx_sampler_reset = 1'b0;
            #1;
            check_reset_vals({tag, "_mid"});
            e = 100;
         end
         e++;
      end
      @(negedge rx_sampler_clk);
      rx_sampler_reset = 1'b0;
   endtask

   // Monitor: counts edges since release and scores the first stop_req_o of each frame.
   int  edge_cnt = 0;
   bit  done_seen = 1'b0;
   initial begin
      exp_t x;
      forever begin
         @(posedge rx_sampler_clk);
         #1;
         if (!rx_sampler_reset) begin
            edge_cnt  = 0;
            done_seen = 1'b0;
         end else begin
            edge_cnt++;
            if (stop_req_o && !done_seen) begin
               done_seen = 1'b1;
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  x = exp_q.pop_front();
                  check("data", {24'd0, data_o}, {24'd0, x.data});
                  check("flags", {28'd0, parity_err_o, frame_err_o, break_o, false_start_o},
                        {28'd0, x.flags});
                  check("done_edge", edge_cnt, x.done_edge);
                  check("busy_at_done", {31'd0, busy_o}, 32'd0);
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] line;

      // 8N1 0x55
      push(8'h55, 4'b0000, 30);
      run_frame("t8n1", expand(frame_bits(8'h55, 8, 0, 1'b0, 1'b1, 1'b1)), 2'd3, 2'b00, 1'b0, 0);

      // 7E1 0x41 with wrong parity bit 1
      push(8'h41, 4'b1000, 30);
      run_frame("t7e1", expand(frame_bits(8'h41, 7, 1, 1'b1, 1'b1, 1'b1)), 2'd2, 2'b10, 1'b0, 0);

      // 5O2 0x15, parity 0 correct; one-sample glitch inside data bit 0 is voted away
      line = expand(frame_bits(8'h15, 5, 1, 1'b0, 1'b1, 1'b1));
      line[4] = ~line[4];
      push(8'h15, 4'b0000, 27);
      run_frame("t5o2", line, 2'd0, 2'b01, 1'b1, 0);

      // Start glitch: 0 for one edge, then idle
      line = '1;
      line[0] = 1'b0;
      push(8'h00, 4'b0001, 3);
      run_frame("tglitch", line, 2'd3, 2'b00, 1'b0, 0);

      // Break, one and two stop bits
      push(8'h00, 4'b0110, 30);
      run_frame("tbrk1", '0, 2'd3, 2'b00, 1'b0, 0);
      push(8'h00, 4'b0110, 30);
      run_frame("tbrk2", '0, 2'd3, 2'b00, 1'b1, 0);

      // 8O2 0x3C, parity 1 correct
      push(8'h3C, 4'b0000, 36);
      run_frame("t8o2", expand(frame_bits(8'h3C, 8, 1, 1'b1, 1'b1, 1'b1)), 2'd3, 2'b01, 1'b1, 0);

      // 6N2 0x2A, second stop bit 0
      push(8'h2A, 4'b0100, 27);
      run_frame("t6n2", expand(frame_bits(8'h2A, 6, 0, 1'b0, 1'b1, 1'b0)), 2'd1, 2'b00, 1'b1, 0);

      // 7O1 all-zero data, parity 0 wrong, stop 0: parity, frame and break together
      push(8'h00, 4'b1110, 30);
      run_frame("t7o1", expand(frame_bits(8'h00, 7, 1, 1'b0, 1'b0, 1'b1)), 2'd2, 2'b01, 1'b0, 0);

      // Reset at edge 14 mid-frame, then a clean 0xA5 frame
      line = expand(frame_bits(8'hA5, 8, 0, 1'b0, 1'b1, 1'b1));
      run_frame("tmid", line, 2'd3, 2'b00, 1'b0, 14);
      push(8'hA5, 4'b0000, 30);
      run_frame("ta5", line, 2'd3, 2'b00, 1'b0, 0);

      repeat (4) @(negedge rx_sampler_clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
